id_hazard_scoreboard: RTL and testbench

//  Parametrised operand-bypass and hazard unit for the ID stage.
//  - Replaces the fixed EX/MEM/WB forwarding muxes and the single-cycle load-use check.
//  - Keeps a per-register pending-result countdown, so a producer of any latency up to
//    MAX_LAT (load, multi-cycle ALU) stalls its consumers for exactly the required cycles.
//  - Muxes NFWD forwarding buses in priority order.
//  - Sits between the regfile read ports and the ID-to-EX bus; its stallreq feeds the CTRL unit.

---
 rtl/id_hazard_scoreboard.sv | 100 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// ID-stage operand bypass and hazard unit.
// Each architectural register carries a pending-result countdown. A consumer
// stalls while any register it reads still has cycles left. Operands come from
// the youngest matching forwarding bus, or from the regfile if no bus matches.
module id_hazard_scoreboard #(
   parameter int DATA_W  = 32,
   parameter int NREG    = 32,
   parameter int NFWD    = 3,
   parameter int MAX_LAT = 4,
   localparam int AW     = $clog2(NREG),
   localparam int LW     = $clog2(MAX_LAT + 1)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   stall_ex,
   input  logic                   flush,
   input  logic                   id_valid,
   input  logic [AW-1:0]          id_rs,
   input  logic                   id_rs_re,
   input  logic [AW-1:0]          id_rt,
   input  logic                   id_rt_re,
   input  logic                   id_we,
   input  logic [AW-1:0]          id_waddr,
   input  logic [LW-1:0]          id_lat,
   input  logic [DATA_W-1:0]      rf_rdata1,
   input  logic [DATA_W-1:0]      rf_rdata2,
   input  logic [NFWD-1:0]        fwd_we,
   input  logic [NFWD*AW-1:0]     fwd_waddr,
   input  logic [NFWD*DATA_W-1:0] fwd_wdata,
   output logic [DATA_W-1:0]      src1_data,
   output logic [DATA_W-1:0]      src2_data,
   output logic                   stallreq,
   output logic                   issue,
   output logic [31:0]            hazard_cnt
);

   logic [LW-1:0] cnt [NREG];
   logic          rs_busy;
   logic          rt_busy;
   logic          haz;
   logic          issue_wr;
   logic [LW-1:0] lat_clamped;

   // A source is busy when it is read, is not $0, and its result is still pending
   always_comb begin
      rs_busy     = id_rs_re && (id_rs != '0) && (cnt[id_rs] != '0);
      rt_busy     = id_rt_re && (id_rt != '0) && (cnt[id_rt] != '0);
      haz         = id_valid && (rs_busy || rt_busy);
      stallreq    = resetn && haz;
      issue       = resetn && id_valid && !haz && !stall_ex && !flush;
      issue_wr    = issue && id_we && (id_waddr != '0);
      lat_clamped = (id_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : id_lat;
   end

   // Operand mux: scan oldest to youngest so the youngest match wins; $0 is always zero
   always_comb begin
      src1_data = rf_rdata1;
      src2_data = rf_rdata2;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == id_rs))
            src1_data = fwd_wdata[i*DATA_W +: DATA_W];
         if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == id_rt))
            src2_data = fwd_wdata[i*DATA_W +: DATA_W];
      end
      if (id_rs == '0)
         src1_data = '0;
      if (id_rt == '0)
         src2_data = '0;
   end

   // Countdowns tick only on cycles the pipeline advances; a new producer reloads its entry
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++)
            cnt[r] <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (!stall_ex && (cnt[r] != '0))
               cnt[r] <= cnt[r] - 1'b1;
         end
         if (issue_wr)
            cnt[id_waddr] <= lat_clamped;
      end
   end

   // Saturating count of cycles spent stalled on an operand hazard
   always_ff @(posedge clk) begin
      if (!resetn)
         hazard_cnt <= '0;
      else if (haz && (hazard_cnt != 32'hFFFF_FFFF))
         hazard_cnt <= hazard_cnt + 32'd1;
   end

   // Producer latencies above MAX_LAT are clamped in hardware and flagged here
   always_ff @(posedge clk) begin
      if (resetn && issue && id_we)
         assert (id_lat <= LW'(MAX_LAT));
   end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Testbench for id_hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a ready-time model of register availability.
module tb_id_hazard_scoreboard;

   localparam int DATA_W  = 32;
   localparam int NREG    = 32;
   localparam int NFWD    = 3;
   localparam int MAX_LAT = 4;
   localparam int AW      = 5;
   localparam int LW      = 3;

   logic                   clk = 1'b0;
   logic                   resetn;
   logic                   stall_ex;
   logic                   flush;
   logic                   id_valid;
   logic [AW-1:0]          id_rs;
   logic                   id_rs_re;
   logic [AW-1:0]          id_rt;
   logic                   id_rt_re;
   logic                   id_we;
   logic [AW-1:0]          id_waddr;
   logic [LW-1:0]          id_lat;
   logic [DATA_W-1:0]      rf_rdata1;
   logic [DATA_W-1:0]      rf_rdata2;
   logic [NFWD-1:0]        fwd_we;
   logic [NFWD*AW-1:0]     fwd_waddr;
   logic [NFWD*DATA_W-1:0] fwd_wdata;
   logic [DATA_W-1:0]      src1_data;
   logic [DATA_W-1:0]      src2_data;
   logic                   stallreq;
   logic                   issue;
   logic [31:0]            hazard_cnt;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: absolute "advancing cycle" at which each register becomes free
   longint      readyAt [NREG];
   longint      activeCycles = 0;
   logic [31:0] modelHaz = '0;

   id_hazard_scoreboard #(
      .DATA_W(DATA_W), .NREG(NREG), .NFWD(NFWD), .MAX_LAT(MAX_LAT)
   ) dut (
      .clk(clk), .resetn(resetn), .stall_ex(stall_ex), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rs_re(id_rs_re),
      .id_rt(id_rt), .id_rt_re(id_rt_re), .id_we(id_we),
      .id_waddr(id_waddr), .id_lat(id_lat),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .src1_data(src1_data), .src2_data(src2_data),
      .stallreq(stallreq), .issue(issue), .hazard_cnt(hazard_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic bit regBusy(input logic [AW-1:0] a);
      return (a != '0) && (readyAt[a] > activeCycles);
   endfunction

   function automatic logic [DATA_W-1:0] resolve(input logic [AW-1:0] a,
                                                 input logic [DATA_W-1:0] rf);
      if (a == '0)
         return '0;
      for (int i = 0; i < NFWD; i++)
         if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == a))
            return fwd_wdata[i*DATA_W +: DATA_W];
      return rf;
   endfunction

   // Check the current inputs against the model, then advance one clock
   task automatic applyStimulus();
      bit hz;
      bit expStall;
      bit expIssue;
      int lat;
      #1;
      hz       = id_valid && ((id_rs_re && regBusy(id_rs)) || (id_rt_re && regBusy(id_rt)));
      expStall = resetn && hz;
      expIssue = resetn && id_valid && !hz && !stall_ex && !flush;
      checkOutput("stallreq", 64'(stallreq), 64'(expStall));
      checkOutput("issue", 64'(issue), 64'(expIssue));
      checkOutput("src1_data", 64'(src1_data), 64'(resolve(id_rs, rf_rdata1)));
      checkOutput("src2_data", 64'(src2_data), 64'(resolve(id_rt, rf_rdata2)));
      checkOutput("hazard_cnt", 64'(hazard_cnt), 64'(modelHaz));
      if (!resetn) begin
         for (int r = 0; r < NREG; r++)
            readyAt[r] = 0;
         modelHaz = '0;
      end else begin
         if (hz && (modelHaz != 32'hFFFF_FFFF))
            modelHaz = modelHaz + 32'd1;
         if (expIssue && id_we && (id_waddr != '0)) begin
            lat = (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
            readyAt[id_waddr] = activeCycles + 1 + longint'(lat);
         end
         if (!stall_ex)
            activeCycles++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic setIdle();
      resetn    = 1'b1;
      stall_ex  = 1'b0;
      flush     = 1'b0;
      id_valid  = 1'b0;
      id_rs     = '0;
      id_rs_re  = 1'b0;
      id_rt     = '0;
      id_rt_re  = 1'b0;
      id_we     = 1'b0;
      id_waddr  = '0;
      id_lat    = '0;
      rf_rdata1 = 32'h1111_1111;
      rf_rdata2 = 32'h2222_2222;
      fwd_we    = '0;
      fwd_waddr = '0;
      fwd_wdata = '0;
   endtask

   task automatic doReset();
      setIdle();
      resetn = 1'b0;
      applyStimulus();
      applyStimulus();
      resetn = 1'b1;
   endtask

   task automatic issueProducer(input logic [AW-1:0] waddr, input logic [LW-1:0] lat);
      setIdle();
      id_valid = 1'b1;
      id_we    = 1'b1;
      id_waddr = waddr;
      id_lat   = lat;
   endtask

   initial begin
      for (int r = 0; r < NREG; r++)
         readyAt[r] = 0;
      setIdle();
      @(negedge clk);
      doReset();

      // T1: reset clears a pending entry and the hazard counter
      issueProducer(5'd5, 3'd3);
      applyStimulus();
      setIdle();
      id_valid = 1'b1; id_rs = 5'd5; id_rs_re = 1'b1;
      #1 checkOutput("t1StallBefore", 64'(stallreq), 64'd1);
      applyStimulus();
      resetn = 1'b0;
      #1 checkOutput("t1StallInReset", 64'(stallreq), 64'd0);
      checkOutput("t1IssueInReset", 64'(issue), 64'd0);
      applyStimulus();
      applyStimulus();
      resetn = 1'b1;
      #1 checkOutput("t1StallAfter", 64'(stallreq), 64'd0);
      checkOutput("t1HazCnt", 64'(hazard_cnt), 64'd0);
      applyStimulus();

      // T2: ALU result forwarded from the youngest bus
      doReset();
      issueProducer(5'd5, 3'd0);
      applyStimulus();
      setIdle();
      id_valid = 1'b1; id_rs = 5'd5; id_rs_re = 1'b1;
      fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd5; fwd_wdata[0 +: DATA_W] = 32'h1234;
      #1 checkOutput("t2Stall", 64'(stallreq), 64'd0);
      checkOutput("t2Src1", 64'(src1_data), 64'h1234);
      applyStimulus();

      // T3: load-use stalls exactly one cycle
      doReset();
      issueProducer(5'd8, 3'd1);
      applyStimulus();
      setIdle();
      id_valid = 1'b1; id_rt = 5'd8; id_rt_re = 1'b1;
      #1 checkOutput("t3Stall", 64'(stallreq), 64'd1);
      applyStimulus();
      fwd_we = 3'b010; fwd_waddr[AW +: AW] = 5'd8; fwd_wdata[DATA_W +: DATA_W] = 32'hDEAD;
      #1 checkOutput("t3NoStall", 64'(stallreq), 64'd0);
      checkOutput("t3Issue", 64'(issue), 64'd1);
      checkOutput("t3Src2", 64'(src2_data), 64'hDEAD);
      checkOutput("t3HazCnt", 64'(hazard_cnt), 64'd1);
      applyStimulus();

      // T4: register zero never stalls and never forwards
      doReset();
      issueProducer(5'd0, 3'd3);
      applyStimulus();
      setIdle();
      id_valid = 1'b1; id_rs = 5'd0; id_rs_re = 1'b1;
      fwd_we = 3'b001; fwd_waddr[0 +: AW] = 5'd0; fwd_wdata[0 +: DATA_W] = 32'hFFFF;
      #1 checkOutput("t4Stall", 64'(stallreq), 64'd0);
      checkOutput("t4Src1", 64'(src1_data), 64'd0);
      applyStimulus();

      // T5: downstream stall freezes the countdown
      doReset();
      issueProducer(5'd9, 3'd2);
      applyStimulus();
      setIdle();
      id_valid = 1'b1; id_rs = 5'd9; id_rs_re = 1'b1;
      for (int k = 0; k < 5; k++) begin
         stall_ex = (k < 3);
         #1 checkOutput("t5Stall", 64'(stallreq), 64'd1);
         applyStimulus();
      end
      stall_ex = 1'b0;
      #1 checkOutput("t5Released", 64'(stallreq), 64'd0);
      checkOutput("t5HazCnt", 64'(hazard_cnt), 64'd5);
      applyStimulus();

      // T6: flushed producer leaves no entry; lowest bus index wins
      doReset();
      issueProducer(5'd4, 3'd3);
      flush = 1'b1;
      #1 checkOutput("t6FlushIssue", 64'(issue), 64'd0);
      applyStimulus();
      setIdle();
      id_valid = 1'b1; id_rs = 5'd4; id_rs_re = 1'b1;
      fwd_we = 3'b101;
      fwd_waddr[0 +: AW] = 5'd4; fwd_wdata[0 +: DATA_W] = 32'hA;
      fwd_waddr[2*AW +: AW] = 5'd4; fwd_wdata[2*DATA_W +: DATA_W] = 32'hB;
      #1 checkOutput("t6Stall", 64'(stallreq), 64'd0);
      checkOutput("t6Src1", 64'(src1_data), 64'hA);
      applyStimulus();

      // Randomized traffic on a small register window to provoke frequent hazards
      doReset();
      for (int n = 0; n < 4000; n++) begin
         resetn    = ($urandom_range(0, 59) != 0);
         stall_ex  = ($urandom_range(0, 4) == 0);
         flush     = ($urandom_range(0, 7) == 0);
         id_valid  = ($urandom_range(0, 9) != 0);
         id_rs     = AW'($urandom_range(0, 7));
         id_rs_re  = ($urandom_range(0, 3) != 0);
         id_rt     = AW'($urandom_range(0, 7));
         id_rt_re  = ($urandom_range(0, 1) != 0);
         id_we     = ($urandom_range(0, 3) != 0);
         id_waddr  = AW'($urandom_range(0, 7));
         id_lat    = LW'($urandom_range(0, MAX_LAT));
         rf_rdata1 = $urandom;
         rf_rdata2 = $urandom;
         fwd_we    = NFWD'($urandom_range(0, 7));
         for (int i = 0; i < NFWD; i++) begin
            fwd_waddr[i*AW +: AW]         = AW'($urandom_range(0, 7));
            fwd_wdata[i*DATA_W +: DATA_W] = $urandom;
         end
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
